sub16_serial: RTL and testbench

Digit-serial 16-bit subtractor with valid/ready handshakes. It computes Z = X − Y over 16/DIGIT_W clock cycles and produces the same five status flags as the combinational 16-bit adder: Sign, Zero, Carry, Parity and Overflow. It gives the arithmetic library its inverse operation. It is intended for area-constrained datapaths that can tolerate multi-cycle latency.

---
 rtl/sub16_serial_pkg.sv | 36 +++
 rtl/sub16_serial_digit_sub.sv | 26 ++
 rtl/sub16_serial.sv | 133 +++++++++++++
 tb/tb_sub16_serial.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sub16_serial_pkg.sv
// Shared definitions for the serial subtractor: data width, FSM states,
// flag bit positions and the flag computation reused by the ALU blocks.
package sub16_serial_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned FLAG_SIGN   = 4;
  localparam int unsigned FLAG_ZERO   = 3;
  localparam int unsigned FLAG_CARRY  = 2;
  localparam int unsigned FLAG_PARITY = 1;
  localparam int unsigned FLAG_OVF    = 0;
  localparam int unsigned FLAG_W      = 5;

  typedef logic [FLAG_W-1:0] flags_t;

  function automatic flags_t calc_flags(input logic [DATA_W-1:0] res,
                                        input logic              cout,
                                        input logic              x_msb,
                                        input logic              y_msb);
    flags_t f;
    f              = '0;
    f[FLAG_SIGN]   = res[DATA_W-1];
    f[FLAG_ZERO]   = (res == '0);
    f[FLAG_CARRY]  = cout;
    f[FLAG_PARITY] = ~^res;
    f[FLAG_OVF]    = (x_msb != y_msb) && (res[DATA_W-1] != x_msb);
    return f;
  endfunction

endpackage

// File: rtl/sub16_serial_digit_sub.sv
// Combinational DIGIT_W-bit ripple slice computing a + b_inv + cin.
module digit_sub #(
  parameter int unsigned DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b_inv,
  input  logic               cin,
  output logic [DIGIT_W-1:0] d,
  output logic               cout
);

  logic [DIGIT_W:0] w_c;

  always_comb begin
    w_c    = '0;
    d      = '0;
    w_c[0] = cin;
    for (int unsigned i = 0; i < DIGIT_W; i++) begin
      d[i]     = a[i] ^ b_inv[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b_inv[i]) | (w_c[i] & (a[i] ^ b_inv[i]));
    end
  end

  assign cout = w_c[DIGIT_W];

endmodule

// File: rtl/sub16_serial.sv
// Digit-serial 16-bit subtractor Z = X - Y with valid/ready handshakes,
// processing DIGIT_W bits per cycle and producing adder-compatible flags.
module sub16_serial
  import sub16_serial_pkg::*;
#(
  parameter int unsigned DIGIT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] X,
  input  logic [DATA_W-1:0] Y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] Z,
  output logic              Sign,
  output logic              Zero,
  output logic              Carry,
  output logic              Parity,
  output logic              Overflow
);

  localparam int unsigned N     = DATA_W / DIGIT_W;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  state_t r_state, w_state_next;

  logic [DATA_W-1:0]         r_x;
  logic [DATA_W-1:0]         r_yn;
  logic [DATA_W-1:0]         r_res;
  logic [DATA_W-1:0]         r_z;
  logic                      r_xmsb;
  logic                      r_ymsb;
  logic                      r_carry;
  logic [CNT_W-1:0]          r_cnt;
  flags_t                    r_flags;

  logic                      w_accept;
  logic                      w_last;
  logic                      w_cout;
  logic [DIGIT_W-1:0]        w_d;
  logic [DATA_W+DIGIT_W-1:0] w_res_cat;
  logic [DATA_W-1:0]         w_res_next;

  assign w_last = (r_cnt == CNT_W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = ~rst;
        w_accept = in_valid & ~rst;
        if (in_valid) w_state_next = RUN;
      end
      RUN: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        out_valid = ~rst;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operands shift right each RUN cycle so the active digit is always at bit 0.
  digit_sub #(.DIGIT_W(DIGIT_W)) u_digit_sub (
    .a     (r_x[DIGIT_W-1:0]),
    .b_inv (r_yn[DIGIT_W-1:0]),
    .cin   (r_carry),
    .d     (w_d),
    .cout  (w_cout)
  );

  assign w_res_cat  = {w_d, r_res};
  assign w_res_next = DATA_W'(w_res_cat >> DIGIT_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x     <= '0;
      r_yn    <= '0;
      r_res   <= '0;
      r_z     <= '0;
      r_xmsb  <= 1'b0;
      r_ymsb  <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_flags <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_x     <= X;
            r_yn    <= ~Y;
            r_xmsb  <= X[DATA_W-1];
            r_ymsb  <= Y[DATA_W-1];
            r_carry <= 1'b1;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_x     <= r_x >> DIGIT_W;
          r_yn    <= r_yn >> DIGIT_W;
          r_res   <= w_res_next;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_z     <= w_res_next;
            r_flags <= calc_flags(w_res_next, w_cout, r_xmsb, r_ymsb);
          end
        end
        default: ;
      endcase
    end
  end

  assign Z        = r_z;
  assign Sign     = r_flags[FLAG_SIGN];
  assign Zero     = r_flags[FLAG_ZERO];
  assign Carry    = r_flags[FLAG_CARRY];
  assign Parity   = r_flags[FLAG_PARITY];
  assign Overflow = r_flags[FLAG_OVF];

endmodule

// File: tb/tb_sub16_serial.sv
// Self-checking bench: one instance per DIGIT_W in {1,2,4,8,16}, all driven
// by the same handshake stream and compared against an arithmetic model.
module tb_sub16_serial;

  localparam int NDUT = 5;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] X;
  logic [15:0] Y;

  logic        rdy [NDUT];
  logic        ov  [NDUT];
  logic [15:0] z   [NDUT];
  logic        sgn [NDUT];
  logic        zro [NDUT];
  logic        cry [NDUT];
  logic        par [NDUT];
  logic        ovf [NDUT];

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    sub16_serial #(.DIGIT_W(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (rdy[g]),
      .X         (X),
      .Y         (Y),
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .Z         (z[g]),
      .Sign      (sgn[g]),
      .Zero      (zro[g]),
      .Carry     (cry[g]),
      .Parity    (par[g]),
      .Overflow  (ovf[g])
    );
  end

  // Returns {Z, Sign, Zero, Carry, Parity, Overflow} from plain arithmetic.
  function automatic logic [20:0] model(input logic [15:0] x, input logic [15:0] y);
    int          d;
    int          sd;
    logic [15:0] r;
    logic        c;
    logic        o;
    d = int'(x) - int'(y);
    if (d < 0) d += 65536;
    r  = 16'(d);
    c  = (x >= y);
    sd = int'($signed(x)) - int'($signed(y));
    o  = (sd > 32767) || (sd < -32768);
    return {r, r[15], (r == 16'h0000), c, (($countones(r) % 2) == 0), o};
  endfunction

  function automatic logic [4:0] flags_of(input int i);
    return {sgn[i], zro[i], cry[i], par[i], ovf[i]};
  endfunction

  task automatic check(input string tag, input int idx, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s dw=%0d observed=%0h expected=%0h", tag, 1 << idx, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit all_ready();
    bit r = 1'b1;
    for (int i = 0; i < NDUT; i++) if (rdy[i] !== 1'b1) r = 1'b0;
    return r;
  endfunction

  // Present operands and take the accept edge; scramble inputs afterwards.
  task automatic start_op(input logic [15:0] x, input logic [15:0] y);
    int w = 0;
    while (!all_ready() && w < 40) begin
      tick();
      w++;
    end
    for (int i = 0; i < NDUT; i++) check("ready_before_accept", i, 32'(rdy[i]), 32'd1);
    X        = x;
    Y        = y;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    X        = 16'($urandom);
    Y        = 16'($urandom);
  endtask

  // Leaves every instance in DONE with out_ready low.
  task automatic wait_results(input logic [15:0] x, input logic [15:0] y, input string tag);
    logic [20:0] e;
    int          lat [NDUT];
    e = model(x, y);
    for (int i = 0; i < NDUT; i++) lat[i] = 0;
    for (int c = 1; c <= 17; c++) begin
      tick();
      for (int i = 0; i < NDUT; i++) if (ov[i] === 1'b1 && lat[i] == 0) lat[i] = c;
    end
    for (int i = 0; i < NDUT; i++) begin
      check({tag, "_latency"}, i, 32'(lat[i]), 32'(16 >> i));
      check({tag, "_Z"}, i, 32'(z[i]), 32'(e[20:5]));
      check({tag, "_flags"}, i, 32'(flags_of(i)), 32'(e[4:0]));
      check({tag, "_in_ready_done"}, i, 32'(rdy[i]), 32'd0);
    end
  endtask

  task automatic release_all();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      check("release_in_ready", i, 32'(rdy[i]), 32'd1);
      check("release_out_valid", i, 32'(ov[i]), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] dx [8];
    logic [15:0] dy [8];
    logic [20:0] eb;
    bit          seen [NDUT];
    logic [15:0] rx;
    logic [15:0] ry;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    X         = '0;
    Y         = '0;
    tick();
    tick();
    for (int i = 0; i < NDUT; i++) begin
      check("rst_in_ready", i, 32'(rdy[i]), 32'd0);
      check("rst_out_valid", i, 32'(ov[i]), 32'd0);
      check("rst_Z", i, 32'(z[i]), 32'd0);
      check("rst_flags", i, 32'(flags_of(i)), 32'd0);
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++) check("post_rst_in_ready", i, 32'(rdy[i]), 32'd1);

    dx = '{16'h8FFF, 16'h0002, 16'h0000, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h8000};
    dy = '{16'h8000, 16'h0002, 16'h0001, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h7FFF};
    for (int t = 0; t < 8; t++) begin
      start_op(dx[t], dy[t]);
      wait_results(dx[t], dy[t], "directed");
      release_all();
    end

    // Backpressure: second op waits on in_valid while DONE holds.
    start_op(16'h1357, 16'h2468);
    wait_results(16'h1357, 16'h2468, "bp_first");
    eb       = model(16'h1357, 16'h2468);
    X        = 16'hAAAA;
    Y        = 16'h5555;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int i = 0; i < NDUT; i++) begin
        check("bp_out_valid", i, 32'(ov[i]), 32'd1);
        check("bp_in_ready", i, 32'(rdy[i]), 32'd0);
        check("bp_Z_hold", i, 32'(z[i]), 32'(eb[20:5]));
        check("bp_flags_hold", i, 32'(flags_of(i)), 32'(eb[4:0]));
      end
    end
    release_all();
    start_op(16'hAAAA, 16'h5555);
    wait_results(16'hAAAA, 16'h5555, "bp_second");
    release_all();

    // Reset two cycles after an accept.
    start_op(16'hFFFF, 16'h0001);
    tick();
    for (int i = 0; i < NDUT; i++) seen[i] = (ov[i] === 1'b1);
    rst = 1'b1;
    #1;
    for (int i = 0; i < NDUT; i++) check("midrst_out_valid_in_rst", i, 32'(ov[i]), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check("midrst_early_valid", i, 32'(seen[i]), (i == 4) ? 32'd1 : 32'd0);
      check("midrst_Z", i, 32'(z[i]), 32'd0);
      check("midrst_flags", i, 32'(flags_of(i)), 32'd0);
      check("midrst_in_ready", i, 32'(rdy[i]), 32'd1);
    end
    for (int i = 0; i < NDUT; i++) seen[i] = 1'b0;
    for (int c = 0; c < 17; c++) begin
      tick();
      for (int i = 0; i < NDUT; i++) if (ov[i] === 1'b1) seen[i] = 1'b1;
    end
    for (int i = 0; i < NDUT; i++) check("midrst_no_valid", i, 32'(seen[i]), 32'd0);
    start_op(16'h1234, 16'h0234);
    wait_results(16'h1234, 16'h0234, "after_rst");
    release_all();

    for (int t = 0; t < 20; t++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      if (t % 5 == 0) ry = rx;
      start_op(rx, ry);
      wait_results(rx, ry, "random");
      release_all();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
